// File: rtl/parking_exit_controller.sv
// Exit-lane gate controller: ticket validation handshake, gate sequencing, lot occupancy
// and a saturating exit counter. Optional REQ timeout enabled by `define EXIT_TIMEOUT_EN.
module parking_exit_controller #(
  parameter int unsigned CAPACITY      = 200,
  parameter int unsigned HOLD_CYCLES   = 3,
  parameter int unsigned VALID_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       car_i,
  input  logic       ticket_i,
  output logic       valid_req_o,
  input  logic       valid_ack_i,
  input  logic       valid_ok_i,
  input  logic       clear_i,
  input  logic       entry_i,
  input  logic       cnt_reset_i,
  output logic       gate_open_o,
  output logic       gate_close_o,
  output logic       red_o,
  output logic       yellow_o,
  output logic       green_o,
  output logic       deny_o,
  output logic [7:0] occupancy_o,
  output logic       full_o,
  output logic [7:0] exit_count_o
);

  localparam logic [7:0] CapVal  = 8'(CAPACITY);
  localparam logic [3:0] HoldMax = 4'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StDeny  = 3'd2,
    StOpen  = 3'd3,
    StHold  = 3'd4,
    StWarn  = 3'd5,
    StClose = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] occ_q, occ_d;
  logic [7:0] exit_cnt_q, exit_cnt_d;
  logic       hold_done;
  logic       exit_event;
  logic       timeout;

`ifdef EXIT_TIMEOUT_EN
  localparam logic [7:0] TimeoutVal = 8'(VALID_TIMEOUT);

  logic [7:0] wait_q, wait_d;

  // Counter is zero in the first REQ cycle; timeout fires in the cycle whose count
  // would reach VALID_TIMEOUT, so REQ lasts exactly VALID_TIMEOUT cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_q != StReq) begin
      wait_d = '0;
    end else if (wait_q != 8'hFF) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign timeout = (state_q == StReq) && ((wait_q + 8'd1) == TimeoutVal);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign hold_done  = (hold_q >= HoldMax);
  assign exit_event = (state_q == StHold) && hold_done && clear_i;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (car_i && ticket_i) state_d = StReq;
      end
      StReq: begin
        // An ack in the timeout cycle still wins.
        if (valid_ack_i) begin
          state_d = valid_ok_i ? StOpen : StDeny;
        end else if (timeout) begin
          state_d = StDeny;
        end
      end
      StDeny:  state_d = StIdle;
      StOpen:  state_d = StHold;
      StHold: begin
        if (hold_done && clear_i) state_d = StWarn;
      end
      StWarn:  state_d = StClose;
      StClose: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    valid_req_o  = 1'b0;
    gate_open_o  = 1'b0;
    gate_close_o = 1'b0;
    deny_o       = 1'b0;
    red_o        = 1'b0;
    yellow_o     = 1'b0;
    green_o      = 1'b0;
    case (state_q)
      StReq: begin
        yellow_o    = 1'b1;
        valid_req_o = 1'b1;
      end
      StDeny: begin
        red_o  = 1'b1;
        deny_o = 1'b1;
      end
      StOpen: begin
        green_o     = 1'b1;
        gate_open_o = 1'b1;
      end
      StHold:  green_o  = 1'b1;
      StWarn:  yellow_o = 1'b1;
      StClose: begin
        red_o        = 1'b1;
        gate_close_o = 1'b1;
      end
      default: red_o = 1'b1;
    endcase
  end

  // Hold timer: zero in the first HOLD cycle, saturating at HOLD_CYCLES
  always_comb begin
    hold_d = hold_q;
    if (state_q == StOpen) begin
      hold_d = '0;
    end else if (state_q == StHold && !hold_done) begin
      hold_d = hold_q + 4'd1;
    end
  end

  // Occupancy: a simultaneous entry and exit cancel out
  always_comb begin
    occ_d = occ_q;
    if (entry_i && exit_event) begin
      occ_d = occ_q;
    end else if (entry_i && (occ_q < CapVal)) begin
      occ_d = occ_q + 8'd1;
    end else if (exit_event && (occ_q != 8'd0)) begin
      occ_d = occ_q - 8'd1;
    end
  end

  always_comb begin
    exit_cnt_d = exit_cnt_q;
    if (cnt_reset_i) begin
      exit_cnt_d = '0;
    end else if (exit_event && (exit_cnt_q != 8'hFF)) begin
      exit_cnt_d = exit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q     <= '0;
      occ_q      <= '0;
      exit_cnt_q <= '0;
    end else begin
      hold_q     <= hold_d;
      occ_q      <= occ_d;
      exit_cnt_q <= exit_cnt_d;
    end
  end

  assign occupancy_o  = occ_q;
  assign exit_count_o = exit_cnt_q;
  assign full_o       = (occ_q == CapVal);

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed self-checking bench for parking_exit_controller (default parameters).
module tb_parking_exit_controller;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       car_i, ticket_i, valid_ack_i, valid_ok_i, clear_i, entry_i, cnt_reset_i;
  logic       valid_req_o, gate_open_o, gate_close_o, red_o, yellow_o, green_o, deny_o;
  logic       full_o;
  logic [7:0] occupancy_o, exit_count_o;

  int checks   = 0;
  int failures = 0;

  parking_exit_controller #(
    .CAPACITY     (200),
    .HOLD_CYCLES  (3),
    .VALID_TIMEOUT(15)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .car_i        (car_i),
    .ticket_i     (ticket_i),
    .valid_req_o  (valid_req_o),
    .valid_ack_i  (valid_ack_i),
    .valid_ok_i   (valid_ok_i),
    .clear_i      (clear_i),
    .entry_i      (entry_i),
    .cnt_reset_i  (cnt_reset_i),
    .gate_open_o  (gate_open_o),
    .gate_close_o (gate_close_o),
    .red_o        (red_o),
    .yellow_o     (yellow_o),
    .green_o      (green_o),
    .deny_o       (deny_o),
    .occupancy_o  (occupancy_o),
    .full_o       (full_o),
    .exit_count_o (exit_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lamps packed as {red, yellow, green}
  function automatic logic [31:0] lamps();
    return {29'd0, red_o, yellow_o, green_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    car_i = 0; ticket_i = 0; valid_ack_i = 0; valid_ok_i = 0;
    clear_i = 0; entry_i = 0; cnt_reset_i = 0;
    reset_i = 1;
    #3;
    @(negedge clk_i);
    reset_i = 0;
  endtask

  task automatic pulse_entries(input int n);
    entry_i = 1;
    repeat (n) step();
    entry_i = 0;
  endtask

  // Full approved exit; entry/cnt_reset optionally coincide with the exit event.
  task automatic run_exit(input logic with_entry, input logic with_cnt_reset);
    car_i = 1; ticket_i = 1;
    step();                          // REQ
    car_i = 0; ticket_i = 0;
    valid_ack_i = 1; valid_ok_i = 1;
    step();                          // OPEN
    valid_ack_i = 0; valid_ok_i = 0;
    repeat (4) step();               // HOLD 0..3
    clear_i = 1; entry_i = with_entry; cnt_reset_i = with_cnt_reset;
    step();                          // WARN
    clear_i = 0; entry_i = 0; cnt_reset_i = 0;
    step();                          // CLOSE
    step();                          // IDLE
  endtask

  initial begin
    reset_i = 1;
    do_reset();
    check_eq("reset_lamps", lamps(), 32'b100);
    check_eq("reset_req", valid_req_o, 1'b0);
    check_eq("reset_occ", occupancy_o, 8'd0);
    check_eq("reset_full", full_o, 1'b0);
    check_eq("reset_cnt", exit_count_o, 8'd0);

    // Approved exit
    pulse_entries(5);
    check_eq("preload_occ", occupancy_o, 8'd5);
    valid_ack_i = 1; valid_ok_i = 1;
    step();
    check_eq("ack_in_idle_ignored", gate_open_o, 1'b0);
    valid_ack_i = 0; valid_ok_i = 0;
    car_i = 1; ticket_i = 1;
    step();
    check_eq("req_latency", valid_req_o, 1'b1);
    check_eq("req_lamps", lamps(), 32'b010);
    ticket_i = 0;
    step();
    check_eq("req_held", valid_req_o, 1'b1);
    valid_ack_i = 1; valid_ok_i = 1;
    step();
    check_eq("open_pulse", gate_open_o, 1'b1);
    check_eq("open_lamps", lamps(), 32'b001);
    check_eq("open_req_low", valid_req_o, 1'b0);
    valid_ack_i = 0; valid_ok_i = 0;
    step();
    check_eq("hold0_open_low", gate_open_o, 1'b0);
    step();
    clear_i = 1;
    step();
    check_eq("early_clear_ignored", lamps(), 32'b001);
    clear_i = 0;
    step();
    clear_i = 1;
    step();
    check_eq("warn_lamps", lamps(), 32'b010);
    check_eq("exit_occ", occupancy_o, 8'd4);
    check_eq("exit_cnt", exit_count_o, 8'd1);
    clear_i = 0; car_i = 0;
    step();
    check_eq("close_pulse", gate_close_o, 1'b1);
    check_eq("close_lamps", lamps(), 32'b100);
    step();
    check_eq("idle_close_low", gate_close_o, 1'b0);

    // Rejected ticket
    car_i = 1; ticket_i = 1;
    step();
    ticket_i = 0;
    valid_ack_i = 1; valid_ok_i = 0;
    step();
    check_eq("deny_pulse", deny_o, 1'b1);
    check_eq("deny_lamps", lamps(), 32'b100);
    check_eq("deny_no_open", gate_open_o, 1'b0);
    check_eq("deny_req_low", valid_req_o, 1'b0);
    valid_ack_i = 0;
    step();
    check_eq("deny_one_cycle", deny_o, 1'b0);
    step();
    check_eq("no_retrigger", valid_req_o, 1'b0);
    check_eq("deny_occ", occupancy_o, 8'd4);
    check_eq("deny_cnt", exit_count_o, 8'd1);
    car_i = 0;

    // Boundaries
    do_reset();
    run_exit(1'b0, 1'b0);
    check_eq("exit_at_zero", occupancy_o, 8'd0);
    pulse_entries(199);
    check_eq("occ_199", occupancy_o, 8'd199);
    check_eq("not_full", full_o, 1'b0);
    pulse_entries(1);
    check_eq("occ_200", occupancy_o, 8'd200);
    check_eq("full", full_o, 1'b1);
    pulse_entries(1);
    check_eq("entry_dropped", occupancy_o, 8'd200);
    run_exit(1'b1, 1'b0);
    check_eq("exit_with_entry", occupancy_o, 8'd200);
    run_exit(1'b0, 1'b0);
    check_eq("exit_from_full", occupancy_o, 8'd199);
    check_eq("full_drop", full_o, 1'b0);

    // Saturation and clear
    do_reset();
    repeat (255) run_exit(1'b0, 1'b0);
    check_eq("cnt_255", exit_count_o, 8'd255);
    run_exit(1'b0, 1'b0);
    check_eq("cnt_sat", exit_count_o, 8'd255);
    run_exit(1'b0, 1'b1);
    check_eq("cnt_clear_wins", exit_count_o, 8'd0);
    check_eq("occ_untouched", occupancy_o, 8'd0);

    // Validation timeout
    do_reset();
    car_i = 1; ticket_i = 1;
    step();
    car_i = 0; ticket_i = 0;
`ifdef EXIT_TIMEOUT_EN
    repeat (14) step();
    check_eq("req_before_timeout", valid_req_o, 1'b1);
    step();
    check_eq("timeout_deny", deny_o, 1'b1);
    step();
    car_i = 1; ticket_i = 1;
    step();
    car_i = 0; ticket_i = 0;
    repeat (14) step();
    valid_ack_i = 1; valid_ok_i = 1;
    step();
    check_eq("ack_beats_timeout", gate_open_o, 1'b1);
    valid_ack_i = 0; valid_ok_i = 0;
`else
    repeat (100) step();
    check_eq("no_timeout_req", valid_req_o, 1'b1);
    check_eq("no_timeout_deny", deny_o, 1'b0);
    valid_ack_i = 1; valid_ok_i = 0;
    step();
    check_eq("late_ack_deny", deny_o, 1'b1);
    valid_ack_i = 0;
    step();
`endif

    // Asynchronous reset in HOLD
    do_reset();
    pulse_entries(3);
    car_i = 1; ticket_i = 1;
    step();
    car_i = 0; ticket_i = 0;
    valid_ack_i = 1; valid_ok_i = 1;
    step();
    valid_ack_i = 0; valid_ok_i = 0;
    step();
    check_eq("in_hold", lamps(), 32'b001);
    #2;
    reset_i = 1;
    #1;
    check_eq("async_lamps", lamps(), 32'b100);
    check_eq("async_occ", occupancy_o, 8'd0);
    #3;
    reset_i = 0;
    step();
    check_eq("post_reset_no_close", gate_close_o, 1'b0);
    check_eq("post_reset_lamps", lamps(), 32'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
